exec_stage: RTL and testbench



---
 rtl/exec_stage.sv | 168 ++++++++++++++++
 tb/tb_exec_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU with NZCV flags plus an iterative shift-add multiplier.
// ALU ops: result one cycle after accept, no backpressure; MUL: stall high MUL_ITERS cycles, upstream holds its register.
module exec_stage #(
  parameter int DATA_W    = 32,
  parameter int MUL_ITERS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] aIn,
  input  logic [DATA_W-1:0] bIn,
  input  logic [DATA_W-1:0] extIn,
  input  logic              aluSrc,
  input  logic [3:0]        aluOp,
  input  logic              setFlags,
  input  logic              validIn,
  input  logic              flush,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags,
  output logic              resValid,
  output logic              stall
);

  localparam int CNT_W = $clog2(MUL_ITERS + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_ITERS - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORR = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_LSL = 4'd6;
  localparam logic [3:0] OP_LSR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic [3:0]        r_flags;
  logic              r_res_vld;
  logic              r_mul_sf;
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W-1:0] w_op2;
  logic [DATA_W-1:0] w_alu_res;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_acc_nxt;
  logic [DATA_W:0]   w_sum;
  logic [4:0]        w_shamt;
  logic              w_c;
  logic              w_v;
  logic              w_accept;
  logic              w_is_mul;
  logic              w_alu_flag_upd;
  logic              w_mul_done;
  logic              w_stall;
  logic [3:0]        w_alu_flags;
  logic [3:0]        w_mul_flags;

  assign w_op2          = aluSrc ? extIn : bIn;
  assign w_shamt        = w_op2[4:0];
  assign w_sum          = {1'b0, aIn} + {1'b0, w_op2};
  assign w_diff         = aIn - w_op2;
  assign w_accept       = (r_state == S_IDLE) && validIn && !flush;
  assign w_is_mul       = (aluOp == OP_MUL);
  assign w_alu_flag_upd = (aluOp == OP_CMP) || (setFlags && (aluOp <= OP_CMP) && !w_is_mul);
  assign w_mul_done     = (r_state == S_MUL) && !flush && (r_cnt == LAST_ITER);
  assign w_acc_nxt      = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_alu_res = '0;
    w_c       = r_flags[2];
    w_v       = r_flags[3];
    case (aluOp)
      OP_ADD: begin
        w_alu_res = w_sum[DATA_W-1:0];
        w_c       = w_sum[DATA_W];
        w_v       = (aIn[DATA_W-1] == w_op2[DATA_W-1]) && (w_sum[DATA_W-1] != aIn[DATA_W-1]);
      end
      OP_SUB, OP_CMP: begin
        w_alu_res = w_diff;
        w_c       = (aIn >= w_op2);
        w_v       = (aIn[DATA_W-1] != w_op2[DATA_W-1]) && (w_diff[DATA_W-1] != aIn[DATA_W-1]);
      end
      OP_AND:  w_alu_res = aIn & w_op2;
      OP_ORR:  w_alu_res = aIn | w_op2;
      OP_EOR:  w_alu_res = aIn ^ w_op2;
      OP_MOV:  w_alu_res = w_op2;
      OP_LSL:  w_alu_res = aIn << w_shamt;
      OP_LSR:  w_alu_res = aIn >> w_shamt;
      default: w_alu_res = '0;
    endcase
  end

  // flags packing: bit0 N, bit1 Z, bit2 C, bit3 V
  assign w_alu_flags = {w_v, w_c, (w_alu_res == '0), w_alu_res[DATA_W-1]};
  assign w_mul_flags = {r_flags[3], r_flags[2], (w_acc_nxt == '0), w_acc_nxt[DATA_W-1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
      S_MUL:   if (flush || (r_cnt == LAST_ITER)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_stall = (r_state == S_MUL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result  <= '0;
      r_flags   <= '0;
      r_res_vld <= 1'b0;
      r_mul_sf  <= 1'b0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
    end else if (r_state == S_IDLE) begin
      r_res_vld <= 1'b0;
      if (w_accept && w_is_mul) begin
        r_mcand  <= aIn;
        r_mplier <= w_op2;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_mul_sf <= setFlags;
      end else if (w_accept) begin
        r_res_vld <= 1'b1;
        if (aluOp != OP_CMP) r_result <= w_alu_res;
        if (w_alu_flag_upd)  r_flags  <= w_alu_flags;
      end
    end else begin
      r_res_vld <= 1'b0;
      // a flush freezes the datapath; the FSM alone handles the abort
      if (!flush) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_W'(1);
        if (w_mul_done) begin
          r_result  <= w_acc_nxt;
          r_res_vld <= 1'b1;
          if (r_mul_sf) r_flags <= w_mul_flags;
        end
      end
    end
  end

  assign result   = r_result;
  assign flags    = r_flags;
  assign resValid = r_res_vld;
  assign stall    = w_stall;

endmodule

// File: tb/tb_exec_stage.sv
// Randomized and directed bench for exec_stage against an arithmetic reference model.
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] aIn, bIn, extIn;
  logic        aluSrc, setFlags, validIn, flush;
  logic [3:0]  aluOp;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        resValid, stall;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_result = '0;
  logic        m_n = 0, m_z = 0, m_c = 0, m_v = 0;

  exec_stage #(.DATA_W(32), .MUL_ITERS(32)) dut (
    .clk(clk), .rst(rst), .aIn(aIn), .bIn(bIn), .extIn(extIn),
    .aluSrc(aluSrc), .aluOp(aluOp), .setFlags(setFlags), .validIn(validIn),
    .flush(flush), .result(result), .flags(flags), .resValid(resValid), .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_flags();
    return {m_v, m_c, m_z, m_n};
  endfunction

  // Architectural effect of one completed op, from plain integer arithmetic.
  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] o2, input logic sf);
    longint unsigned ua, ub;
    longint sa, sb, exact;
    logic [31:0] r;
    logic wr, nz, cv, nc, nv;
    ua = a; ub = o2; sa = $signed(a); sb = $signed(o2);
    wr = 1; nz = 1; cv = 0; nc = m_c; nv = m_v; exact = 0;
    case (op)
      4'd0: begin r = 32'(ua + ub); nc = ((ua + ub) >> 32) != 0; exact = sa + sb; cv = 1; end
      4'd1, 4'd9: begin r = 32'(ua - ub); nc = (ua >= ub); exact = sa - sb; cv = 1; wr = (op != 4'd9); end
      4'd2: r = a & o2;
      4'd3: r = a | o2;
      4'd4: r = a ^ o2;
      4'd5: r = o2;
      4'd6: r = 32'(ua << o2[4:0]);
      4'd7: r = a >> o2[4:0];
      4'd8: r = 32'(ua * ub);
      default: begin r = '0; nz = 0; end
    endcase
    if (cv) nv = (exact != longint'($signed(r)));
    if (wr) m_result = r;
    if (nz && (sf || op == 4'd9)) begin
      m_n = r[31];
      m_z = (r == 0);
      if (cv) begin m_c = nc; m_v = nv; end
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input logic src, input logic sf);
    aluOp = op; aIn = a; bIn = b; extIn = e; aluSrc = src; setFlags = sf; validIn = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(4'd0, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checks += 4;
    if (result !== 32'h0)  begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    if (flags !== 4'h0)    begin errors++; $display("FAIL reset_flags: got %b want 0000", flags); end
    if (resValid !== 1'b0) begin errors++; $display("FAIL reset_resValid: got %b want 0", resValid); end
    if (stall !== 1'b0)    begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    validIn = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_flags();
    drive(4'd0, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1);
    model_apply(4'd0, 32'h7FFF_FFFF, 32'h1, 1'b1);
    @(negedge clk);
    validIn = 1'b0;
    checks += 3;
    if (resValid !== 1'b1)         begin errors++; $display("FAIL add_resValid: got %b want 1", resValid); end
    if (result !== 32'h8000_0000)  begin errors++; $display("FAIL add_result: got %h want 80000000", result); end
    if (flags !== 4'b1001)         begin errors++; $display("FAIL add_flags(VCZN): got %b want 1001", flags); end
    @(negedge clk);
    checks += 2;
    if (resValid !== 1'b0)         begin errors++; $display("FAIL add_pulse_end: got %b want 0", resValid); end
    if (result !== 32'h8000_0000)  begin errors++; $display("FAIL add_hold: got %h want 80000000", result); end
  endtask

  task automatic test_cmp();
    drive(4'd9, 32'd5, 32'hDEAD_BEEF, 32'd5, 1'b1, 1'b0);
    model_apply(4'd9, 32'd5, 32'd5, 1'b0);
    @(negedge clk);
    validIn = 1'b0;
    checks += 3;
    if (resValid !== 1'b1)        begin errors++; $display("FAIL cmp_resValid: got %b want 1", resValid); end
    if (result !== 32'h8000_0000) begin errors++; $display("FAIL cmp_result_kept: got %h want 80000000", result); end
    if (flags !== 4'b0110)        begin errors++; $display("FAIL cmp_flags(VCZN): got %b want 0110", flags); end
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [31:0] a, b, e, old_r;
    logic [3:0]  old_f;
    logic        src;
    int          n;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin a = 32'h0001_0003; b = 32'h7; e = 32'h0; src = 1'b0; end
      else begin a = $urandom; b = $urandom; e = $urandom; src = 1'($urandom_range(0, 1)); end
      old_r = m_result;
      old_f = m_flags();
      drive(4'd8, a, b, e, src, 1'b1);
      model_apply(4'd8, a, src ? e : b, 1'b1);
      n = 0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (!stall) begin validIn = 1'b0; break; end
        n++;
        aluOp = 4'd0; aIn = $urandom; bIn = $urandom; validIn = 1'b1;
        checks++;
        if (resValid !== 1'b0 || result !== old_r || flags !== old_f) begin
          errors++;
          $display("FAIL mul_busy cycle %0d: resValid=%b result=%h flags=%b want 0/%h/%b", n, resValid, result, flags, old_r, old_f);
        end
      end
      checks += 4;
      if (n !== 32)            begin errors++; $display("FAIL mul_stall_len: got %0d want 32", n); end
      if (resValid !== 1'b1)   begin errors++; $display("FAIL mul_resValid: got %b want 1", resValid); end
      if (result !== m_result) begin errors++; $display("FAIL mul_result: got %h want %h", result, m_result); end
      if (flags !== m_flags()) begin errors++; $display("FAIL mul_flags: got %b want %b", flags, m_flags()); end
      @(negedge clk);
      checks += 2;
      if (resValid !== 1'b0)   begin errors++; $display("FAIL mul_pulse_end: got %b want 0", resValid); end
      if (result !== m_result) begin errors++; $display("FAIL mul_hold: got %h want %h", result, m_result); end
    end
  endtask

  task automatic test_flush_mul();
    int at;
    int seen;
    for (int k = 0; k < 2; k++) begin
      at = (k == 0) ? 10 : 32;
      drive(4'd8, 32'h0000_0F0F, 32'h0000_0303, 32'h0, 1'b0, 1'b1);
      for (int c = 0; c < at; c++) begin
        @(negedge clk);
        validIn = 1'b0;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL flush_pre_stall cycle %0d: got %b want 1", c, stall); end
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks += 4;
      if (stall !== 1'b0)       begin errors++; $display("FAIL flush%0d_stall: got %b want 0", at, stall); end
      if (resValid !== 1'b0)    begin errors++; $display("FAIL flush%0d_resValid: got %b want 0", at, resValid); end
      if (result !== m_result)  begin errors++; $display("FAIL flush%0d_result: got %h want %h", at, result, m_result); end
      if (flags !== m_flags())  begin errors++; $display("FAIL flush%0d_flags: got %b want %b", at, flags, m_flags()); end
      seen = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (resValid || stall) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL flush%0d_late_activity: got %0d want 0", at, seen); end
    end
  endtask

  task automatic test_flush_idle();
    drive(4'd0, 32'h1111_1111, 32'h2222_2222, 32'h0, 1'b0, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    validIn = 1'b0;
    checks += 3;
    if (resValid !== 1'b0)   begin errors++; $display("FAIL flush_idle_resValid: got %b want 0", resValid); end
    if (result !== m_result) begin errors++; $display("FAIL flush_idle_result: got %h want %h", result, m_result); end
    if (flags !== m_flags()) begin errors++; $display("FAIL flush_idle_flags: got %b want %b", flags, m_flags()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [3];
    drive(4'd0, 32'd100, 32'd23, 32'd0, 1'b0, 1'b0);
    model_apply(4'd0, 32'd100, 32'd23, 1'b0); want[0] = m_result;
    @(negedge clk);
    drive(4'd1, 32'd20, 32'd5, 32'd0, 1'b0, 1'b0);
    checks += 2;
    if (resValid !== 1'b1)   begin errors++; $display("FAIL b2b_add_vld: got %b want 1", resValid); end
    if (result !== want[0])  begin errors++; $display("FAIL b2b_add: got %h want %h", result, want[0]); end
    model_apply(4'd1, 32'd20, 32'd5, 1'b0); want[1] = m_result;
    @(negedge clk);
    drive(4'd6, 32'd1, 32'd0, 32'd31, 1'b1, 1'b0);
    checks += 2;
    if (resValid !== 1'b1)   begin errors++; $display("FAIL b2b_sub_vld: got %b want 1", resValid); end
    if (result !== want[1])  begin errors++; $display("FAIL b2b_sub: got %h want %h", result, want[1]); end
    model_apply(4'd6, 32'd1, 32'd31, 1'b0);
    @(negedge clk);
    validIn = 1'b0;
    checks += 2;
    if (resValid !== 1'b1)        begin errors++; $display("FAIL b2b_lsl_vld: got %b want 1", resValid); end
    if (result !== 32'h8000_0000) begin errors++; $display("FAIL b2b_lsl: got %h want 80000000", result); end
    @(negedge clk);
    checks++;
    if (resValid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", resValid); end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b, e;
    logic        src, sf, v;
    for (int i = 0; i < 120; i++) begin
      op  = 4'($urandom_range(0, 15));
      if (op == 4'd8) op = 4'd1;
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      e   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      src = 1'($urandom_range(0, 1));
      sf  = 1'($urandom_range(0, 1));
      v   = ($urandom_range(0, 3) != 0);
      drive(op, a, b, e, src, sf);
      validIn = v;
      if (v) model_apply(op, a, src ? e : b, sf);
      @(negedge clk);
      checks += 3;
      if (resValid !== v)      begin errors++; $display("FAIL rand%0d_vld op=%0d: got %b want %b", i, op, resValid, v); end
      if (result !== m_result) begin errors++; $display("FAIL rand%0d_result op=%0d: got %h want %h", i, op, result, m_result); end
      if (flags !== m_flags()) begin errors++; $display("FAIL rand%0d_flags op=%0d: got %b want %b", i, op, flags, m_flags()); end
    end
    validIn = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_async();
    drive(4'd8, 32'h0000_1234, 32'h0000_0055, 32'h0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL arst_pre_stall: got %b want 1", stall); end
    #2;
    rst = 1'b0;
    #1;
    checks += 4;
    if (stall !== 1'b0)    begin errors++; $display("FAIL arst_stall: got %b want 0", stall); end
    if (result !== 32'h0)  begin errors++; $display("FAIL arst_result: got %h want 0", result); end
    if (flags !== 4'h0)    begin errors++; $display("FAIL arst_flags: got %b want 0000", flags); end
    if (resValid !== 1'b0) begin errors++; $display("FAIL arst_resValid: got %b want 0", resValid); end
    @(negedge clk);
    validIn = 1'b0;
    rst = 1'b1;
    m_result = '0; m_n = 0; m_z = 0; m_c = 0; m_v = 0;
    repeat (2) @(negedge clk);
    checks += 2;
    if (stall !== 1'b0 || resValid !== 1'b0) begin errors++; $display("FAIL arst_after: stall=%b resValid=%b want 0/0", stall, resValid); end
    if (result !== 32'h0) begin errors++; $display("FAIL arst_after_result: got %h want 0", result); end
  endtask

  initial begin
    rst = 1'b0; aIn = '0; bIn = '0; extIn = '0; aluSrc = 1'b0; aluOp = '0;
    setFlags = 1'b0; validIn = 1'b0; flush = 1'b0;
    @(negedge clk);
    test_reset();
    test_add_flags();
    test_cmp();
    test_mul();
    test_flush_mul();
    test_flush_idle();
    test_back_to_back();
    test_random();
    test_reset_async();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
